// File: rtl/fetch_decode_stall_unit.sv
// Fetch/decode stall unit: PC register, IF/ID register and ID/EX bubble flag.
// It arbitrates load-use stalls against taken-branch redirects. A stall FSM
// with a consecutive-stall watchdog and a hazard-protocol checker sits alongside.
module fetch_decode_stall_unit #(
  parameter int unsigned                PC_WIDTH    = 32,
  parameter int unsigned                INSTR_WIDTH = 16,
  parameter logic [INSTR_WIDTH-1:0]     NOP_INSTR   = '0,
  parameter logic [PC_WIDTH-1:0]        RESET_PC    = '0,
  parameter int unsigned                MAX_STALL   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Keep_PC,
  input  logic                   Keep_Fetched_Instruction,
  input  logic                   Flush_MUX_Selector,
  input  logic                   Branch_Taken,
  input  logic [PC_WIDTH-1:0]    Branch_Target,
  input  logic [INSTR_WIDTH-1:0] Fetched_Instr,
  output logic [PC_WIDTH-1:0]    PC_Out,
  output logic [INSTR_WIDTH-1:0] IFID_Instr,
  output logic [PC_WIDTH-1:0]    IFID_PC,
  output logic                   IFID_Valid,
  output logic                   IDEX_Bubble,
  output logic [1:0]             Stall_State,
  output logic                   Stall_Timeout,
  output logic                   Protocol_Err
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_STALL);

  state_t                   state_q, state_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]   ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]      ifid_pc_q, ifid_pc_d;
  logic                     ifid_valid_q, ifid_valid_d;
  logic                     idex_bubble_q, idex_bubble_d;
  logic [3:0]               stall_cnt_q, stall_cnt_d;
  logic                     stall_timeout_q, stall_timeout_d;
  logic                     protocol_err_q, protocol_err_d;

  logic                     stall_accept;
  logic [3:0]               stall_cnt_inc;

  assign stall_accept  = Keep_PC & ~Branch_Taken;
  assign stall_cnt_inc = (stall_cnt_q >= MAX_CNT) ? MAX_CNT : stall_cnt_q + 4'd1;

  // Datapath next-state: branch redirect beats stall, stall beats normal advance.
  always_comb begin
    pc_d          = pc_q + 1'b1;
    ifid_instr_d  = Fetched_Instr;
    ifid_pc_d     = pc_q;
    ifid_valid_d  = 1'b1;
    idex_bubble_d = Flush_MUX_Selector & ~Branch_Taken;
    if (Branch_Taken) begin
      pc_d         = Branch_Target;
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
    end else if (Keep_PC) begin
      pc_d = pc_q;
      if (Keep_Fetched_Instruction) begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
      end
    end
  end

  // Stall FSM next-state plus watchdog counter and protocol checker.
  always_comb begin
    state_d         = state_q;
    stall_cnt_d     = '0;
    stall_timeout_d = stall_timeout_q;
    protocol_err_d  = protocol_err_q;

    case (state_q)
      ST_RUN, ST_STALL, ST_REDIRECT: begin
        if (Branch_Taken)      state_d = ST_REDIRECT;
        else if (stall_accept) state_d = ST_STALL;
        else                   state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (stall_accept) begin
      stall_cnt_d = stall_cnt_inc;
      if (stall_cnt_inc == MAX_CNT) stall_timeout_d = 1'b1;
    end

    if (~Branch_Taken & ~Keep_PC & (Keep_Fetched_Instruction | Flush_MUX_Selector))
      protocol_err_d = 1'b1;
  end

  // Register bank with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_RUN;
      pc_q            <= RESET_PC;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_q       <= '0;
      ifid_valid_q    <= 1'b0;
      idex_bubble_q   <= 1'b0;
      stall_cnt_q     <= '0;
      stall_timeout_q <= 1'b0;
      protocol_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_valid_q    <= ifid_valid_d;
      idex_bubble_q   <= idex_bubble_d;
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
      protocol_err_q  <= protocol_err_d;
    end
  end

  assign PC_Out        = pc_q;
  assign IFID_Instr    = ifid_instr_q;
  assign IFID_PC       = ifid_pc_q;
  assign IFID_Valid    = ifid_valid_q;
  assign IDEX_Bubble   = idex_bubble_q;
  assign Stall_State   = state_q;
  assign Stall_Timeout = stall_timeout_q;
  assign Protocol_Err  = protocol_err_q;

endmodule

// File: tb/tb_fetch_decode_stall_unit.sv
// Directed bench for fetch_decode_stall_unit with hand-computed expectations.
module tb_fetch_decode_stall_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        keep_pc = 1'b0;
  logic        keep_fi = 1'b0;
  logic        flush = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [15:0] fetched = '0;
  logic [31:0] pc_out;
  logic [15:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        idex_bubble;
  logic [1:0]  stall_state;
  logic        stall_timeout;
  logic        protocol_err;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  fetch_decode_stall_unit #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (16),
    .NOP_INSTR   (16'h0000),
    .RESET_PC    (32'h0),
    .MAX_STALL   (4)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .Keep_PC                  (keep_pc),
    .Keep_Fetched_Instruction (keep_fi),
    .Flush_MUX_Selector       (flush),
    .Branch_Taken             (br_taken),
    .Branch_Target            (br_target),
    .Fetched_Instr            (fetched),
    .PC_Out                   (pc_out),
    .IFID_Instr               (ifid_instr),
    .IFID_PC                  (ifid_pc),
    .IFID_Valid               (ifid_valid),
    .IDEX_Bubble              (idex_bubble),
    .Stall_State              (stall_state),
    .Stall_Timeout            (stall_timeout),
    .Protocol_Err             (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hz(input logic kp, input logic kf, input logic fl,
                        input logic bt, input logic [31:0] tgt, input logic [15:0] fi);
    keep_pc   = kp;
    keep_fi   = kf;
    flush     = fl;
    br_taken  = bt;
    br_target = tgt;
    fetched   = fi;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_pc"},      pc_out,        32'h0);
    check_eq({tag, "_instr"},   ifid_instr,    32'h0);
    check_eq({tag, "_ifidpc"},  ifid_pc,       32'h0);
    check_eq({tag, "_valid"},   ifid_valid,    32'h0);
    check_eq({tag, "_bubble"},  idex_bubble,   32'h0);
    check_eq({tag, "_state"},   stall_state,   32'h0);
    check_eq({tag, "_timeout"}, stall_timeout, 32'h0);
    check_eq({tag, "_perr"},    protocol_err,  32'h0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_state("rst");
    @(negedge clk);
    rst = 1'b0;

    // Free-running fetch.
    for (int i = 1; i <= 3; i++) begin
      set_hz(0, 0, 0, 0, 32'h0, 16'hA000 + 16'(i));
      tick();
      check_eq("run_pc",     pc_out,     32'(i));
      check_eq("run_instr",  ifid_instr, 32'h0000A000 + 32'(i));
      check_eq("run_ifidpc", ifid_pc,    32'(i - 1));
      check_eq("run_valid",  ifid_valid, 32'h1);
      check_eq("run_state",  stall_state, 32'h0);
    end
    set_hz(0, 0, 0, 0, 32'h0, 16'hA004); tick();
    set_hz(0, 0, 0, 0, 32'h0, 16'hA005); tick();
    check_eq("pre_lu_pc", pc_out, 32'h5);

    // One-cycle load-use stall at PC=5.
    set_hz(1, 1, 1, 0, 32'h0, 16'hA006);
    tick();
    check_eq("lu_pc",     pc_out,      32'h5);
    check_eq("lu_instr",  ifid_instr,  32'hA005);
    check_eq("lu_ifidpc", ifid_pc,     32'h4);
    check_eq("lu_bubble", idex_bubble, 32'h1);
    check_eq("lu_state",  stall_state, 32'h1);
    check_eq("lu_perr",   protocol_err, 32'h0);
    set_hz(0, 0, 0, 0, 32'h0, 16'hA006);
    tick();
    check_eq("lu2_pc",     pc_out,      32'h6);
    check_eq("lu2_instr",  ifid_instr,  32'hA006);
    check_eq("lu2_ifidpc", ifid_pc,     32'h5);
    check_eq("lu2_bubble", idex_bubble, 32'h0);
    check_eq("lu2_state",  stall_state, 32'h0);

    // Branch overrides all hazard inputs.
    set_hz(1, 1, 1, 1, 32'h40, 16'hBEEF);
    tick();
    check_eq("br_pc",     pc_out,      32'h40);
    check_eq("br_valid",  ifid_valid,  32'h0);
    check_eq("br_instr",  ifid_instr,  32'h0);
    check_eq("br_ifidpc", ifid_pc,     32'h0);
    check_eq("br_bubble", idex_bubble, 32'h0);
    check_eq("br_state",  stall_state, 32'h2);
    check_eq("br_perr",   protocol_err, 32'h0);
    set_hz(0, 0, 0, 0, 32'h0, 16'hB040);
    tick();
    check_eq("br2_pc",     pc_out,      32'h41);
    check_eq("br2_state",  stall_state, 32'h0);
    check_eq("br2_instr",  ifid_instr,  32'hB040);
    check_eq("br2_ifidpc", ifid_pc,     32'h40);

    // Four-cycle stall trips the watchdog on the 4th edge.
    set_hz(1, 1, 0, 0, 32'h0, 16'hB041);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("wd_pc",      pc_out,        32'h41);
      check_eq("wd_state",   stall_state,   32'h1);
      check_eq("wd_timeout", stall_timeout, (i == 4) ? 32'h1 : 32'h0);
    end
    set_hz(0, 0, 0, 0, 32'h0, 16'hB041);
    tick();
    check_eq("wd_rel_pc",      pc_out,        32'h42);
    check_eq("wd_rel_state",   stall_state,   32'h0);
    check_eq("wd_rel_timeout", stall_timeout, 32'h1);

    // PC wrap from all-ones.
    set_hz(0, 0, 0, 1, 32'hFFFF_FFFF, 16'h0);
    tick();
    check_eq("wrap_pre_pc", pc_out, 32'hFFFF_FFFF);
    set_hz(0, 0, 0, 0, 32'h0, 16'hC000);
    tick();
    check_eq("wrap_pc",     pc_out,      32'h0);
    check_eq("wrap_ifidpc", ifid_pc,     32'hFFFF_FFFF);
    check_eq("wrap_state",  stall_state, 32'h0);

    // Keep_Fetched_Instruction alone is a protocol error; IF/ID still advances.
    set_hz(0, 1, 0, 0, 32'h0, 16'hC001);
    tick();
    check_eq("perr_flag",   protocol_err, 32'h1);
    check_eq("perr_pc",     pc_out,       32'h1);
    check_eq("perr_instr",  ifid_instr,   32'hC001);
    check_eq("perr_ifidpc", ifid_pc,      32'h0);
    set_hz(0, 0, 0, 0, 32'h0, 16'hC002);
    tick();
    check_eq("perr_sticky", protocol_err, 32'h1);

    // Asynchronous reset in the middle of a stall.
    set_hz(1, 1, 1, 0, 32'h0, 16'hC003);
    tick();
    check_eq("ms_state",  stall_state, 32'h1);
    check_eq("ms_bubble", idex_bubble, 32'h1);
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    rst = 1'b0;
    set_hz(0, 0, 0, 0, 32'h0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stall_unit.md
Name: fetch_decode_stall_unit

Overview:
- Receiving end of the load-use hazard interface: consumes Keep_PC, Keep_Fetched_Instruction and Flush_MUX_Selector, and owns the registers those signals act on.
- Holds the PC register and the IF/ID pipeline register, and registers the ID/EX bubble flag.
- Arbitrates hazard stalls against taken-branch redirects.
- Adds a stall FSM with a consecutive-stall watchdog and protocol checking.

Parameters:
- PC_WIDTH, 32, PC and branch-target width; PC is word-addressed.
- INSTR_WIDTH, 16, fetched instruction width.
- NOP_INSTR, 0, encoding loaded into IF/ID on squash.
- RESET_PC, 0, PC value on reset.
- MAX_STALL, 4, consecutive stall cycles allowed before Stall_Timeout; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- Keep_PC  in  1  hold PC this cycle (hazard request).
- Keep_Fetched_Instruction  in  1  hold IF/ID this cycle.
- Flush_MUX_Selector  in  1  insert bubble into ID/EX.
- Branch_Taken  in  1  redirect request from EX.
- Branch_Target  in  PC_WIDTH  redirect address.
- Fetched_Instr  in  INSTR_WIDTH  instruction memory data at PC_Out.
- PC_Out  out  PC_WIDTH  current fetch address (registered).
- IFID_Instr  out  INSTR_WIDTH  decode-stage instruction.
- IFID_PC  out  PC_WIDTH  PC of IFID_Instr.
- IFID_Valid  out  1  IFID_Instr is a real instruction.
- IDEX_Bubble  out  1  ID/EX loaded with NOP this cycle (registered).
- Stall_State  out  2  FSM state: 0 RUN, 1 STALL, 2 REDIRECT.
- Stall_Timeout  out  1  sticky: MAX_STALL consecutive stalls reached.
- Protocol_Err  out  1  sticky: illegal hazard-input combination.

Behaviour:
- Reset (asynchronous, immediate, any time including mid-stall):
  - PC_Out=RESET_PC, IFID_Instr=NOP_INSTR, IFID_PC=0, IFID_Valid=0, IDEX_Bubble=0.
  - State=RUN, stall counter=0, Stall_Timeout=0, Protocol_Err=0.
- Registers update on the posedge. Priority per cycle: Branch_Taken > stall (Keep_PC) > normal.
- Normal, no branch and Keep_PC=0:
  - PC_Out<=PC_Out+1, wrapping modulo 2^PC_WIDTH (all-ones -> 0).
  - IFID_Instr<=Fetched_Instr, IFID_PC<=PC_Out, IFID_Valid<=1.
- Stall, Keep_PC=1 and no branch:
  - PC_Out holds.
  - If Keep_Fetched_Instruction=1, IFID_Instr, IFID_PC and IFID_Valid hold.
- Bubble: IDEX_Bubble<=Flush_MUX_Selector & ~Branch_Taken. One-cycle pulse per sampled request; stays high across back-to-back requests.
- Branch, Branch_Taken=1, overriding all hazard inputs in the same cycle:
  - PC_Out<=Branch_Target.
  - IFID_Instr<=NOP_INSTR, IFID_Valid<=0, IFID_PC<=0.
  - IDEX_Bubble<=0. Stall counter cleared.
- FSM:
  - RUN -> STALL on an accepted stall.
  - RUN/STALL -> REDIRECT on Branch_Taken.
  - STALL -> STALL while stall persists. Counter increments, saturating at MAX_STALL.
  - STALL -> RUN when Keep_PC=0 and no branch. Counter cleared.
  - REDIRECT -> RUN next cycle if no stall and no branch; -> STALL on stall; stays REDIRECT on another branch.
  - REDIRECT always lasts at least 1 cycle.
  - Stall_State reflects the registered state.
- Watchdog: Stall_Timeout set on the edge where the counter reaches MAX_STALL. Sticky until reset. Does not alter datapath behaviour.
- Protocol_Err is set, sticky, when any of these is sampled at a clock edge:
  - Keep_Fetched_Instruction=1 with Keep_PC=0, or
  - Flush_MUX_Selector=1 with Keep_PC=0, both with Branch_Taken=0.
  - Datapath then follows the Keep_PC value.
- Latency: PC_Out and IFID_* are 1 cycle from input sample; no combinational input-to-output paths.

Test Plan:
- Reset then 3 free-running cycles, Fetched_Instr=16'hA001,16'hA002,16'hA003 -> PC_Out=1,2,3; IFID_Instr=A001..A003; IFID_PC=0,1,2; IFID_Valid=1 from cycle 1; Stall_State=0.
- One-cycle load-use, all three hazard inputs high at PC=5 -> PC_Out stays 5 one cycle; IFID holds; IDEX_Bubble=1 for exactly 1 cycle; Stall_State 1 then 0; Protocol_Err=0.
- Hazard inputs high together with Branch_Taken=1, Branch_Target=32'h40 -> PC_Out=0x40; IFID_Valid=0; IFID_Instr=NOP_INSTR; IDEX_Bubble=0; Stall_State=2, then 0 next cycle.
- Keep_PC held 4 cycles with MAX_STALL=4 -> Stall_Timeout rises on the 4th edge and stays set after the stall releases; PC resumes incrementing.
- PC at 32'hFFFFFFFF, no stall -> PC_Out=0. Keep_Fetched_Instruction=1 alone -> Protocol_Err=1 sticky and IF/ID advances.
- rst asserted mid-stall, asynchronously between edges -> all outputs at reset values immediately, before the next clk edge.
